// File: rtl/corner_scan_ctrl_if.sv
// Handshake between corner_scan_ctrl and find_corners: scan address, result
// pulse with the four edges, and the one-cycle start flag.
interface corner_scan_ctrl_if;
    logic [16:0] fc_addr_in;
    logic        fc_valid_in;
    logic [7:0]  fc_right_in;
    logic [7:0]  fc_left_in;
    logic [8:0]  fc_top_in;
    logic [8:0]  fc_bot_in;
    logic        fc_start_out;

    // find_corners side: drives address and results, receives the start flag
    modport master (
        output fc_addr_in, fc_valid_in, fc_right_in, fc_left_in, fc_top_in, fc_bot_in,
        input  fc_start_out
    );

    // Controller side
    modport slave (
        input  fc_addr_in, fc_valid_in, fc_right_in, fc_left_in, fc_top_in, fc_bot_in,
        output fc_start_out
    );
endinterface

// File: rtl/corner_scan_ctrl.sv
// Frame-buffer port arbiter: gives the BRAM port to find_corners once per clean
// frame, starts the scan, latches the edges and hands the port back to the camera.
module corner_scan_ctrl #(
    parameter int WIDTH   = 240,
    parameter int HEIGHT  = 320,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic        frame_done_in,
    input  logic        cam_we_in,
    input  logic [16:0] cam_addr_in,
    input  logic [15:0] cam_data_in,
    input  logic [7:0]  x_center_in,
    input  logic [8:0]  y_center_in,
    corner_scan_ctrl_if.slave fc,
    output logic [16:0] bram_addr_out,
    output logic        bram_we_out,
    output logic [15:0] bram_din_out,
    output logic [7:0]  x_center_out,
    output logic [8:0]  y_center_out,
    output logic [7:0]  right_edge_out,
    output logic [7:0]  left_edge_out,
    output logic [8:0]  top_edge_out,
    output logic [8:0]  bot_edge_out,
    output logic        result_valid_out,
    output logic        error_out,
    output logic        busy_out,
    output logic [15:0] drop_count_out,
    output logic [2:0]  dbg_state
);
    // A scan always gets at least enough cycles to walk both axes.
    localparam int LIMIT = (TIMEOUT > WIDTH + HEIGHT) ? TIMEOUT : WIDTH + HEIGHT + 1;
    localparam int TW    = $clog2(LIMIT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        FILL  = 3'd2,
        START = 3'd3,
        SCAN  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state, next_state;
    logic [TW-1:0] timer;
    logic        timed_out;
    logic [7:0]  x_q;
    logic [8:0]  y_q;

    assign timed_out = (state == SCAN) && (timer == TW'(LIMIT - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            timer          <= '0;
            x_q            <= '0;
            y_q            <= '0;
            right_edge_out <= '0;
            left_edge_out  <= '0;
            top_edge_out   <= '0;
            bot_edge_out   <= '0;
            error_out      <= 1'b0;
            drop_count_out <= '0;
        end else begin
            state <= next_state;
            if (state == START) begin
                timer <= '0;
                x_q   <= x_center_in;
                y_q   <= y_center_in;
            end else if (state == SCAN) begin
                timer <= timer + 1'b1;
            end
            // A result arriving on the timeout cycle still counts as a result.
            if (state == SCAN && fc.fc_valid_in) begin
                right_edge_out <= fc.fc_right_in;
                left_edge_out  <= fc.fc_left_in;
                top_edge_out   <= fc.fc_top_in;
                bot_edge_out   <= fc.fc_bot_in;
                error_out      <= (fc.fc_left_in >= fc.fc_right_in) ||
                                  (fc.fc_top_in >= fc.fc_bot_in);
            end else if (timed_out) begin
                error_out <= 1'b1;
            end
            if (busy_out && cam_we_in && drop_count_out != 16'hFFFF)
                drop_count_out <= drop_count_out + 16'd1;
        end
    end

    always_comb begin
        next_state       = state;
        busy_out         = 1'b0;
        fc.fc_start_out  = 1'b0;
        result_valid_out = 1'b0;
        bram_addr_out    = cam_addr_in;
        bram_we_out      = cam_we_in;
        bram_din_out     = cam_data_in;
        x_center_out     = x_q;
        y_center_out     = y_q;
        dbg_state        = state;
        case (state)
            IDLE:  if (enable_in) next_state = SYNC;
            SYNC:  if (!enable_in) next_state = IDLE;
                   else if (frame_done_in) next_state = FILL;
            FILL:  if (!enable_in) next_state = IDLE;
                   else if (frame_done_in) next_state = START;
            START: next_state = SCAN;
            SCAN:  if (fc.fc_valid_in || timed_out) next_state = DONE;
            DONE:  next_state = enable_in ? SYNC : IDLE;
            default: next_state = IDLE;
        endcase
        if (state == START || state == SCAN || state == DONE) begin
            busy_out      = 1'b1;
            bram_addr_out = fc.fc_addr_in;
            bram_we_out   = 1'b0;
            bram_din_out  = '0;
        end
        // Center is visible during START itself, then held from the register.
        if (state == START) begin
            fc.fc_start_out = 1'b1;
            x_center_out    = x_center_in;
            y_center_out    = y_center_in;
        end
        if (state == DONE) result_valid_out = 1'b1;
    end
endmodule

// File: doc/corner_scan_ctrl.md
# corner_scan_ctrl

Sequencer and port arbiter for the frame-buffer BRAM shared by the camera write path and `find_corners`. Each time a full, clean frame has landed in the buffer, it hands the single BRAM port to `find_corners` and issues its one-cycle start flag. It holds the port until the scan completes or times out, then latches the four edges and returns the port to the camera. It sits between the camera/frame-buffer writer, the frame-buffer RAM and `find_corners`.

## Interface
Parameters:
- `WIDTH`, 240, frame width in pixels.
- `HEIGHT`, 320, frame height in pixels.
- `TIMEOUT`, 1024, maximum cycles allowed in SCAN; must be greater than WIDTH+HEIGHT.

Ports:
- `clk_in` input 1: system clock.
- `rst_in` input 1: reset, synchronous, active-high.
- `enable_in` input 1: level; permits new scans.
- `frame_done_in` input 1: one-cycle pulse from the camera writer after the last pixel of a frame.
- `cam_we_in` input 1: camera write enable.
- `cam_addr_in` input 17: camera write address.
- `cam_data_in` input 16: camera pixel.
- `x_center_in` input 8: scan center x, sampled at the START state.
- `y_center_in` input 9: scan center y, sampled at the START state.
- `fc_addr_in` input 17: `find_corners` address output.
- `fc_valid_in` input 1: `find_corners` data-valid pulse.
- `fc_right_in`, `fc_left_in` input 8: edge results from `find_corners`.
- `fc_top_in`, `fc_bot_in` input 9: edge results from `find_corners`.
- `bram_addr_out` output 17: address to the frame BRAM.
- `bram_we_out` output 1: write enable to the frame BRAM.
- `bram_din_out` output 16: write data to the frame BRAM.
- `fc_start_out` output 1: `find_corners_flag`.
- `x_center_out` output 8, `y_center_out` output 9: latched center, held stable through the scan.
- `right_edge_out`, `left_edge_out` output 8: latched edge results.
- `top_edge_out`, `bot_edge_out` output 9: latched edge results.
- `result_valid_out` output 1: one-cycle pulse when a result is published.
- `error_out` output 1: level; the last result was bad (timeout or inverted edges).
- `busy_out` output 1: high while `find_corners` owns the port.
- `drop_count_out` output 16: count of camera writes discarded.

## Operation
States: IDLE, SYNC, FILL, START, SCAN, DONE.

Port ownership:
- Camera owns the port in IDLE, SYNC and FILL.
- `find_corners` owns the port in START, SCAN and DONE.

Port multiplexing:
- The mux is combinational from the registered state; no added latency on the `find_corners` read path.
- In camera-owned states: `bram_addr_out`=`cam_addr_in`, `bram_we_out`=`cam_we_in`, `bram_din_out`=`cam_data_in`.
- In scan-owned states: `bram_addr_out`=`fc_addr_in`, `bram_we_out`=0, `bram_din_out`=0.

Transitions:
- IDLE → SYNC when `enable_in`=1.
- SYNC → FILL on `frame_done_in`. This discards the partial frame present at entry.
- FILL → START on `frame_done_in`. The buffer now holds one complete frame.
- START lasts exactly 1 cycle. It asserts `fc_start_out`, latches the center inputs and clears the timeout counter. START → SCAN.
- SCAN → DONE on `fc_valid_in`, or when the timeout counter reaches TIMEOUT−1.
- DONE lasts exactly 1 cycle. DONE → SYNC if `enable_in`=1, else → IDLE.
- `enable_in` low in SYNC or FILL → IDLE. `enable_in` low in START or SCAN has no effect; the scan completes.

Result latching (on the cycle `fc_valid_in`=1 in SCAN):
- Capture all four `fc_*` edge inputs.
- `error_out` is set to (left ≥ right) or (top ≥ bot).
- On timeout, the edge outputs hold their previous values and `error_out`=1.
- If `fc_valid_in` and timeout coincide, valid wins: the result is latched normally.

Other rules:
- `result_valid_out` pulses in DONE.
- `busy_out` = state ∈ {START, SCAN, DONE}.
- `drop_count_out` increments on each cycle with `cam_we_in`=1 while scan-owned. It saturates at 0xFFFF and is cleared only by reset.
- `frame_done_in` outside SYNC or FILL is ignored.

## Timing
- Reset:
  - State returns to IDLE.
  - All outputs are 0, including latched edges, center, error and drop count.
  - The port returns to the camera the cycle after reset is asserted, even mid-scan.
  - `find_corners` is reset by the same `rst_in`.
- `fc_start_out` is high exactly one cycle: the cycle after the FILL-state `frame_done_in`.
- `x_center_out`/`y_center_out` are valid from the START cycle and are held until the next START.
- Result timing:
  - `fc_valid_in` at cycle N: DONE and `result_valid_out` at N+1.
  - Latched edges and `error_out` are visible at N+1.
  - Camera owns the port again at N+2.
- Timeout: DONE occurs TIMEOUT cycles after entering SCAN.
- Frame cadence: at most one scan per two `frame_done_in` pulses. The frame written during a scan is always skipped via SYNC.

## Test plan
- **Normal scan:** enable, two `frame_done` pulses, `find_corners` model returns valid after 560 cycles with left=80, right=160, top=100, bot=220.
  - `fc_start_out` is a single cycle after the 2nd pulse.
  - `result_valid_out` pulses once; edges match; `error_out`=0; `busy_out` falls at DONE+1.
- **Port mux:** camera writes 0x00FF at address 0x1234 in FILL.
  - Appears on the BRAM port with we=1.
  - In SCAN, `bram_addr_out` tracks `fc_addr_in` cycle-for-cycle with we=0.
- **Timeout:** no `fc_valid_in` arrives.
  - DONE exactly 1024 cycles after SCAN entry; `error_out`=1; edges hold prior values.
- **Inverted result:** left=200, right=50.
  - `error_out`=1; edges still latched.
- **Drops and saturation:**
  - 100 camera writes during SCAN → `drop_count_out`=100.
  - Preload near the limit → holds at 0xFFFF.
- **Reset mid-SCAN and enable drop:**
  - `rst_in` mid-SCAN → IDLE next cycle, all outputs 0.
  - `enable_in`=0 during SCAN → scan finishes, then IDLE, with no further `fc_start_out` on later frames.
